mem_arbiter: RTL and testbench

- Shares a single external memory port between the fetch unit's instruction request channel and the LSU's data request channel.
- Sits between the core's two cache-style interfaces (inst_* and data_*) and one unified memory bus (mem_*).
- Grants one requester at a time and holds the transaction until the memory responds.
- Returns a registered response to the winner; round-robin fairness resolves simultaneous requests.

---
 rtl/core_pkg.sv | 22 ++
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_arbiter.sv | 558 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the memory-port arbiter: FSM states,
// grant identities and the full byte-enable mask used for instruction fetches.
package core_pkg;

  localparam int DATA_WIDTH_DEF      = 32;
  localparam int BYTE_DATA_WIDTH_DEF = DATA_WIDTH_DEF / 8;

  localparam logic [BYTE_DATA_WIDTH_DEF-1:0] BE_ALL = {BYTE_DATA_WIDTH_DEF{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  typedef enum logic {
    GNT_INST = 1'b0,
    GNT_DATA = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-to-one memory port arbiter between instruction fetch and LSU requests.
// Round-robin on ties; every output is registered so no request/response path is combinational.
module mem_arbiter
  import core_pkg::*;
#(
  parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int BYTE_DATA_WIDTH = BYTE_DATA_WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,

  input  logic                       inst_req,
  input  logic [DATA_WIDTH-1:0]      inst_addr,
  output logic                       inst_valid,
  output logic [DATA_WIDTH-1:0]      inst_data,

  input  logic                       data_req,
  input  logic                       data_we,
  input  logic [BYTE_DATA_WIDTH-1:0] byte_enable,
  input  logic [DATA_WIDTH-1:0]      data_addr,
  input  logic [DATA_WIDTH-1:0]      wdata,
  output logic                       data_valid,
  output logic [DATA_WIDTH-1:0]      rdata,

  output logic                       mem_req,
  output logic                       mem_we,
  output logic [BYTE_DATA_WIDTH-1:0] mem_be,
  output logic [DATA_WIDTH-1:0]      mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_wdata,
  input  logic                       mem_valid,
  input  logic [DATA_WIDTH-1:0]      mem_rdata
);

  localparam logic [BYTE_DATA_WIDTH-1:0] BE_FULL = {BYTE_DATA_WIDTH{1'b1}};

  arb_state_t                 state_q, state_d;
  grant_t                     last_grant_q, last_grant_d;
  logic                       mem_req_q, mem_req_d;
  logic                       mem_we_q, mem_we_d;
  logic [BYTE_DATA_WIDTH-1:0] mem_be_q, mem_be_d;
  logic [DATA_WIDTH-1:0]      mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]      mem_wdata_q, mem_wdata_d;
  logic                       inst_valid_q, inst_valid_d;
  logic [DATA_WIDTH-1:0]      inst_data_q, inst_data_d;
  logic                       data_valid_q, data_valid_d;
  logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
  logic                       grant_inst;

  // Fetch wins when alone, or on a tie when the LSU was served last.
  assign grant_inst = inst_req && (!data_req || (last_grant_q == GNT_DATA));

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_be_d     = mem_be_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    inst_valid_d = 1'b0;
    inst_data_d  = '0;
    data_valid_d = 1'b0;
    rdata_d      = '0;

    case (state_q)
      IDLE: begin
        if (grant_inst) begin
          state_d      = BUSY_I;
          last_grant_d = GNT_INST;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_be_d     = BE_FULL;
          mem_addr_d   = inst_addr;
          mem_wdata_d  = '0;
        end else if (data_req) begin
          state_d      = BUSY_D;
          last_grant_d = GNT_DATA;
          mem_req_d    = 1'b1;
          mem_we_d     = data_we;
          mem_be_d     = byte_enable;
          mem_addr_d   = data_addr;
          mem_wdata_d  = wdata;
        end
      end

      // Captured request fields stay frozen here; only mem_valid moves us on.
      BUSY_I, BUSY_D: begin
        if (mem_valid) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          if (state_q == BUSY_I) begin
            inst_valid_d = 1'b1;
            inst_data_d  = mem_rdata;
          end else begin
            data_valid_d = 1'b1;
            rdata_d      = mem_we_q ? '0 : mem_rdata;
          end
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset abandons any in-flight access; last_grant starts at DATA so fetch wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_DATA;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      inst_valid_q <= 1'b0;
      inst_data_q  <= '0;
      data_valid_q <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      inst_valid_q <= inst_valid_d;
      inst_data_q  <= inst_data_d;
      data_valid_q <= data_valid_d;
      rdata_q      <= rdata_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_be     = mem_be_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign inst_valid = inst_valid_q;
  assign inst_data  = inst_data_q;
  assign data_valid = data_valid_q;
  assign rdata      = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by a randomized
// run scored against a transaction-level arbitration and memory model.
module tb_mem_arbiter;

  localparam int DW = 32;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          inst_req;
  logic [DW-1:0] inst_addr;
  logic          inst_valid;
  logic [DW-1:0] inst_data;
  logic          data_req;
  logic          data_we;
  logic [BW-1:0] byte_enable;
  logic [DW-1:0] data_addr;
  logic [DW-1:0] wdata;
  logic          data_valid;
  logic [DW-1:0] rdata;
  logic          mem_req;
  logic          mem_we;
  logic [BW-1:0] mem_be;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_valid;
  logic [DW-1:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  int mem_wait   = 0;
  bit mem_enable = 1'b1;
  int wait_cnt   = 0;

  logic [31:0] phys_mem [logic [31:0]];
  logic [31:0] ref_mem  [logic [31:0]];

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_WIDTH(DW), .BYTE_DATA_WIDTH(BW)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_valid(inst_valid), .inst_data(inst_data),
    .data_req(data_req), .data_we(data_we), .byte_enable(byte_enable), .data_addr(data_addr),
    .wdata(wdata), .data_valid(data_valid), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_valid(mem_valid), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] merge_be(input logic [31:0] old_w, input logic [31:0] new_w,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] phys_read(input logic [31:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // Memory responder: answers a held mem_req after mem_wait idle cycles; store responses carry junk data.
  initial begin
    mem_valid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_valid = 1'b0;
      mem_rdata = '0;
      if (rst || mem_req !== 1'b1 || !mem_enable) begin
        wait_cnt = 0;
      end else if (wait_cnt >= mem_wait) begin
        mem_valid = 1'b1;
        if (mem_we) begin
          phys_mem[mem_addr] = merge_be(phys_read(mem_addr), mem_wdata, mem_be);
          mem_rdata = 32'hBAD0_BAD0;
        end else begin
          mem_rdata = phys_read(mem_addr);
        end
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    inst_req    = 1'b0;
    inst_addr   = '0;
    data_req    = 1'b0;
    data_we     = 1'b0;
    byte_enable = '0;
    data_addr   = '0;
    wdata       = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bit got;
    $display("[TB] test_reset");
    drive_idle();
    mem_enable = 1'b1;
    mem_wait   = 0;
    inst_req   = 1'b1;
    inst_addr  = 32'h40;
    rst        = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      total++;
      if ({mem_req, mem_we, inst_valid, data_valid} !== 4'b0000) begin
        bad++;
        $display("[TB] FAIL reset_ctrl: got req/we/iv/dv=%b expected 0000",
                 {mem_req, mem_we, inst_valid, data_valid});
      end
      total++;
      if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_be !== 4'h0) begin
        bad++;
        $display("[TB] FAIL reset_mem_fields: got addr=%h wdata=%h be=%h expected all 0",
                 mem_addr, mem_wdata, mem_be);
      end
      total++;
      if (inst_data !== 32'h0 || rdata !== 32'h0) begin
        bad++;
        $display("[TB] FAIL reset_resp_data: got inst_data=%h rdata=%h expected 0", inst_data, rdata);
      end
    end
    rst = 1'b0;
    tick();
    total++;
    if (mem_req !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_release_req: got %b expected 1", mem_req);
    end
    total++;
    if (mem_addr !== 32'h40) begin
      bad++;
      $display("[TB] FAIL reset_release_addr: got %h expected 00000040", mem_addr);
    end
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      tick();
      if (inst_valid === 1'b1) got = 1'b1;
    end
    total++;
    if (!got) begin
      bad++;
      $display("[TB] FAIL reset_first_fetch: got no inst_valid expected one within 10 cycles");
    end
    inst_req = 1'b0;
    tick();
  endtask

  task automatic test_single_fetch();
    int pulses;
    int vcycle;
    $display("[TB] test_single_fetch");
    drive_idle();
    phys_mem[32'h100] = 32'h0050_0093;
    mem_wait  = 2;
    inst_req  = 1'b1;
    inst_addr = 32'h100;
    pulses    = 0;
    vcycle    = -1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) begin
        total++;
        if ({mem_req, mem_we, mem_be} !== 6'b1_0_1111 || mem_addr !== 32'h100 || mem_wdata !== 32'h0) begin
          bad++;
          $display("[TB] FAIL fetch_mem_fields: got req=%b we=%b be=%h addr=%h wdata=%h expected 1 0 f 00000100 0",
                   mem_req, mem_we, mem_be, mem_addr, mem_wdata);
        end
      end
      if (inst_valid === 1'b1) begin
        pulses++;
        if (vcycle < 0) vcycle = c;
        total++;
        if (inst_data !== 32'h0050_0093) begin
          bad++;
          $display("[TB] FAIL fetch_data: got %h expected 00500093", inst_data);
        end
        inst_req = 1'b0;
      end
      total++;
      if (data_valid !== 1'b0) begin
        bad++;
        $display("[TB] FAIL fetch_no_data_valid: got %b expected 0 (cycle %0d)", data_valid, c);
      end
    end
    total++;
    if (pulses != 1) begin
      bad++;
      $display("[TB] FAIL fetch_pulse_count: got %0d expected 1", pulses);
    end
    total++;
    if (vcycle != 4) begin
      bad++;
      $display("[TB] FAIL fetch_latency: got valid at cycle %0d expected 4", vcycle);
    end
  endtask

  task automatic test_single_store();
    int pulses;
    int vcycle;
    $display("[TB] test_single_store");
    drive_idle();
    mem_wait    = 1;
    data_req    = 1'b1;
    data_we     = 1'b1;
    data_addr   = 32'h2004;
    wdata       = 32'hDEAD_BEEF;
    byte_enable = 4'h3;
    pulses      = 0;
    vcycle      = -1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) begin
        total++;
        if ({mem_req, mem_we, mem_be} !== 6'b1_1_0011 || mem_addr !== 32'h2004 || mem_wdata !== 32'hDEAD_BEEF) begin
          bad++;
          $display("[TB] FAIL store_mem_fields: got req=%b we=%b be=%h addr=%h wdata=%h expected 1 1 3 00002004 deadbeef",
                   mem_req, mem_we, mem_be, mem_addr, mem_wdata);
        end
      end
      if (data_valid === 1'b1) begin
        pulses++;
        if (vcycle < 0) vcycle = c;
        total++;
        if (rdata !== 32'h0) begin
          bad++;
          $display("[TB] FAIL store_rdata: got %h expected 0", rdata);
        end
        data_req = 1'b0;
        data_we  = 1'b0;
      end
      total++;
      if (inst_valid !== 1'b0) begin
        bad++;
        $display("[TB] FAIL store_no_inst_valid: got %b expected 0 (cycle %0d)", inst_valid, c);
      end
    end
    total++;
    if (pulses != 1 || vcycle != 3) begin
      bad++;
      $display("[TB] FAIL store_pulse: got %0d pulses at cycle %0d expected 1 at cycle 3", pulses, vcycle);
    end
  endtask

  task automatic test_fairness();
    int  grants[$];
    int  vseq[$];
    int  overlap;
    logic prev_mreq;
    $display("[TB] test_fairness");
    drive_idle();
    mem_wait = 0;
    do_reset();
    inst_req  = 1'b1;
    inst_addr = 32'h300;
    data_req  = 1'b1;
    data_we   = 1'b0;
    data_addr = 32'h400;
    overlap   = 0;
    prev_mreq = 1'b0;
    for (int c = 0; c < 40 && vseq.size() < 4; c++) begin
      tick();
      if (mem_req === 1'b1 && prev_mreq !== 1'b1)
        grants.push_back(mem_addr === 32'h300 ? 0 : (mem_addr === 32'h400 ? 1 : 2));
      prev_mreq = mem_req;
      if (inst_valid === 1'b1 && data_valid === 1'b1) overlap++;
      if (inst_valid === 1'b1) vseq.push_back(0);
      if (data_valid === 1'b1) vseq.push_back(1);
    end
    drive_idle();
    tick();
    tick();
    total++;
    if (grants.size() < 4 || vseq.size() < 4) begin
      bad++;
      $display("[TB] FAIL tie_count: got %0d grants %0d valids expected 4 each", grants.size(), vseq.size());
    end
    for (int i = 0; i < 4 && i < grants.size(); i++) begin
      total++;
      if (grants[i] != i % 2) begin
        bad++;
        $display("[TB] FAIL tie_grant_order[%0d]: got %0d expected %0d (0=INST 1=DATA)", i, grants[i], i % 2);
      end
    end
    for (int i = 0; i < 4 && i < vseq.size(); i++) begin
      total++;
      if (vseq[i] != i % 2) begin
        bad++;
        $display("[TB] FAIL tie_valid_order[%0d]: got %0d expected %0d", i, vseq[i], i % 2);
      end
    end
    total++;
    if (overlap != 0) begin
      bad++;
      $display("[TB] FAIL tie_valid_overlap: got %0d overlapping cycles expected 0", overlap);
    end
  endtask

  task automatic test_busy_hold();
    bit done;
    $display("[TB] test_busy_hold");
    drive_idle();
    mem_wait  = 3;
    data_req  = 1'b1;
    data_we   = 1'b0;
    data_addr = 32'h40;
    done      = 1'b0;
    for (int c = 0; c < 15 && !done; c++) begin
      tick();
      if (data_valid === 1'b1) begin
        done = 1'b1;
        total++;
        if (rdata !== phys_read(32'h40)) begin
          bad++;
          $display("[TB] FAIL busy_rdata: got %h expected %h", rdata, phys_read(32'h40));
        end
        data_req = 1'b0;
        data_we  = 1'b0;
      end else if (mem_req === 1'b1) begin
        total++;
        if (mem_addr !== 32'h40 || mem_we !== 1'b0) begin
          bad++;
          $display("[TB] FAIL busy_hold: got addr=%h we=%b expected 00000040 0", mem_addr, mem_we);
        end
        data_addr = 32'h80;
        data_we   = 1'b1;
        wdata     = $urandom;
      end
    end
    total++;
    if (!done) begin
      bad++;
      $display("[TB] FAIL busy_complete: got no data_valid expected one within 15 cycles");
    end
    drive_idle();
    tick();
  endtask

  task automatic test_reset_mid();
    int order[$];
    $display("[TB] test_reset_mid");
    drive_idle();
    mem_enable = 1'b0;
    data_req   = 1'b1;
    data_addr  = 32'h500;
    tick();
    total++;
    if (mem_req !== 1'b1) begin
      bad++;
      $display("[TB] FAIL rstmid_req_before: got %b expected 1", mem_req);
    end
    tick();
    rst = 1'b1;
    tick();
    total++;
    if (mem_req !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rstmid_req_drop: got %b expected 0", mem_req);
    end
    total++;
    if (data_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rstmid_no_valid: got %b expected 0", data_valid);
    end
    rst        = 1'b0;
    mem_enable = 1'b1;
    mem_wait   = 0;
    inst_req   = 1'b1;
    inst_addr  = 32'h600;
    tick();
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h600 || mem_we !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rstmid_first_grant: got req=%b addr=%h we=%b expected 1 00000600 0",
               mem_req, mem_addr, mem_we);
    end
    for (int c = 0; c < 20 && order.size() < 2; c++) begin
      tick();
      if (inst_valid === 1'b1) begin
        order.push_back(0);
        total++;
        if (inst_data !== phys_read(32'h600)) begin
          bad++;
          $display("[TB] FAIL rstmid_inst_data: got %h expected %h", inst_data, phys_read(32'h600));
        end
        inst_req = 1'b0;
      end
      if (data_valid === 1'b1) begin
        order.push_back(1);
        data_req = 1'b0;
      end
    end
    total++;
    if (order.size() != 2 || order[0] != 0 || order[1] != 1) begin
      bad++;
      $display("[TB] FAIL rstmid_order: got %0d completions (first=%0d) expected INST then DATA",
               order.size(), order.size() > 0 ? order[0] : -1);
    end
    drive_idle();
    tick();
  endtask

  // Transaction-level model: a free cycle grants from that cycle's requests, a busy
  // transaction ends on mem_valid, and the response shows one cycle after that.
  task automatic test_random();
    bit          m_busy, m_resp, m_owner, m_last, was_free;
    bit          p_i, p_d, prev_i, prev_d;
    logic [31:0] ti_addr, td_addr, td_wdata, e_addr, e_wdata, e_data;
    logic        td_we, e_we;
    logic [3:0]  td_be, e_be;
    logic        exp_iv, exp_dv;
    int          age_i, age_d, done_n;
    $display("[TB] test_random");
    drive_idle();
    phys_mem.delete();
    ref_mem.delete();
    mem_enable = 1'b1;
    mem_wait   = 0;
    do_reset();
    m_busy = 0; m_resp = 0; m_owner = 0; m_last = 1;
    p_i = 0; p_d = 0; prev_i = 0; prev_d = 0;
    age_i = 0; age_d = 0; done_n = 0;
    ti_addr = '0; td_addr = '0; td_wdata = '0; td_we = 0; td_be = '0;
    e_addr = '0; e_wdata = '0; e_data = '0; e_we = 0; e_be = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      tick();
      was_free = !m_busy && !m_resp;
      m_resp   = 1'b0;
      if (m_busy && mem_valid === 1'b1) begin
        m_busy = 1'b0;
        m_resp = 1'b1;
        if (m_owner == 1'b1 && e_we) begin
          e_data = '0;
          ref_mem[e_addr] = merge_be(ref_read(e_addr), e_wdata, e_be);
        end else begin
          e_data = ref_read(e_addr);
        end
      end else if (was_free && (prev_i || prev_d)) begin
        m_owner = (prev_i && (!prev_d || m_last == 1'b1)) ? 1'b0 : 1'b1;
        m_last  = m_owner;
        m_busy  = 1'b1;
        if (m_owner == 1'b0) begin
          e_addr = ti_addr; e_we = 1'b0; e_be = 4'hF; e_wdata = '0;
        end else begin
          e_addr = td_addr; e_we = td_we; e_be = td_be; e_wdata = td_wdata;
        end
        mem_wait = $urandom_range(0, 3);
      end

      total++;
      if (mem_req !== m_busy) begin
        bad++;
        $display("[TB] FAIL rand_mem_req: got %b expected %b (cycle %0d)", mem_req, m_busy, cyc);
      end
      if (m_busy) begin
        total++;
        if (mem_addr !== e_addr || mem_we !== e_we || mem_be !== e_be || mem_wdata !== e_wdata) begin
          bad++;
          $display("[TB] FAIL rand_mem_fields: got %h/%b/%h/%h expected %h/%b/%h/%h (cycle %0d)",
                   mem_addr, mem_we, mem_be, mem_wdata, e_addr, e_we, e_be, e_wdata, cyc);
        end
      end
      exp_iv = m_resp && (m_owner == 1'b0);
      exp_dv = m_resp && (m_owner == 1'b1);
      total++;
      if (inst_valid !== exp_iv || data_valid !== exp_dv) begin
        bad++;
        $display("[TB] FAIL rand_valids: got iv=%b dv=%b expected iv=%b dv=%b (cycle %0d)",
                 inst_valid, data_valid, exp_iv, exp_dv, cyc);
      end
      if (m_resp) begin
        done_n++;
        total++;
        if ((m_owner == 1'b0) ? (inst_data !== e_data) : (rdata !== e_data)) begin
          bad++;
          $display("[TB] FAIL rand_resp_data: got %h expected %h (owner %0d cycle %0d)",
                   (m_owner == 1'b0) ? inst_data : rdata, e_data, m_owner, cyc);
        end
      end

      if (m_resp && m_owner == 1'b0) p_i = 1'b0;
      if (m_resp && m_owner == 1'b1) p_d = 1'b0;
      if (!p_i && $urandom_range(0, 2) == 0) begin
        p_i = 1'b1; age_i = 0;
        ti_addr = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
      end
      if (!p_d && $urandom_range(0, 2) == 0) begin
        p_d = 1'b1; age_d = 0;
        td_addr  = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
        td_we    = 1'($urandom_range(0, 1));
        td_be    = 4'($urandom_range(1, 15));
        td_wdata = $urandom;
      end
      if (p_i) age_i++;
      if (p_d) age_d++;
      inst_req    = p_i;
      inst_addr   = p_i ? ti_addr : $urandom;
      data_req    = p_d;
      data_addr   = p_d ? td_addr : $urandom;
      data_we     = p_d ? td_we : 1'b0;
      byte_enable = p_d ? td_be : 4'h0;
      wdata       = p_d ? td_wdata : $urandom;
      prev_i      = p_i;
      prev_d      = p_d;
      if (age_i > 60 || age_d > 60) begin
        total++;
        bad++;
        $display("[TB] FAIL rand_timeout: got request age %0d/%0d expected at most 60 cycles", age_i, age_d);
        break;
      end
      if (bad > 40) break;
    end
    total++;
    if (done_n < 50) begin
      bad++;
      $display("[TB] FAIL rand_progress: got %0d completions expected at least 50", done_n);
    end
    drive_idle();
    repeat (8) tick();
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_single_fetch();
    test_single_store();
    test_fairness();
    test_busy_hold();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
